video_timing_generator: RTL and testbench
=========================================

VIDEO_TIMING_GENERATOR -- requirements
Module: video_timing_generator

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16; H_SYNC, default 96; H_BACK, default 48 (horizontal porch and sync widths, pixels).
REQ-003 SHALL have parameter V_VISIBLE, default 480; V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33 (lines).
REQ-004 SHALL have parameter FB_WIDTH, default 320, framebuffer pixels per row (2x pixel doubling).
REQ-005 SHALL have port clock, input, 1, pixel clock (25.175 MHz nominal); all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port frame_select_memory, input, 1, software frame select request.
REQ-008 SHALL have port framebuffer_address, output, 17, read address to synchronous framebuffer RAMs.
REQ-009 SHALL have port pixel_x_pos, output, 10, registered horizontal position aligned with RAM data.
REQ-010 SHALL have port pixel_y_pos, output, 10, registered vertical position aligned with RAM data.
REQ-011 SHALL have ports vga_hsync and vga_vsync, outputs, 1 each, active-low sync pulses.
REQ-012 SHALL have port video_active, output, 1, high when pixel_x_pos < H_VISIBLE and pixel_y_pos < V_VISIBLE.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse with pixel_x_pos = 0, pixel_y_pos = 0.
REQ-014 SHALL have port frame_select_latched, output, 1, tear-free frame select for the compositor.

Function
REQ-015 h_count SHALL count 0 .. H_TOTAL-1 (H_TOTAL = sum of H_* = 800) and wrap to 0.
REQ-016 v_count SHALL increment only when h_count wraps, count 0 .. V_TOTAL-1 (525), and wrap to 0 when both wrap.
REQ-017 framebuffer_address SHALL be combinational from current counters: (v_count>>1)*FB_WIDTH + (h_count>>1) when h_count < H_VISIBLE and v_count < V_VISIBLE, else 0.
REQ-018 Stage 2 (pixel_x_pos, pixel_y_pos, vga_hsync, vga_vsync, video_active, frame_start) SHALL be registered copies of stage-1 values: latency exactly 1 clock, matching the RAM read latency.
REQ-019 Internal hsync SHALL be low for H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC (656..751), high otherwise.
REQ-020 Internal vsync SHALL be low for V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC (490..491), high otherwise, for whole lines.
REQ-021 pixel_x_pos/pixel_y_pos SHALL carry raw delayed counter values, including blanking values up to 799/524.
REQ-022 frame_select_latched SHALL load frame_select_memory only on the cycle h_count = 0, v_count = V_VISIBLE; it SHALL hold at all other cycles.
REQ-023 Address arithmetic SHALL be unsigned, at least 17 bits; maximum address 239*320+319 = 76799.
REQ-024 frame_start SHALL pulse exactly once per V_TOTAL*H_TOTAL = 420000 cycles.

Reset
REQ-025 While reset is high, h_count, v_count SHALL be 0 at the next edge; pixel_x_pos = 0, pixel_y_pos = 0, vga_hsync = 1, vga_vsync = 1, video_active = 0, frame_start = 0, frame_select_latched = 0.
REQ-026 framebuffer_address SHALL read 0 during reset (counters at 0).
REQ-027 Reset asserted mid-frame SHALL abort the frame; the first cycle after deassertion SHALL have counters at (0,0), and frame_start SHALL pulse on the following cycle.
REQ-028 Reset SHALL take priority over counting and the frame-select latch on the same edge.

Verification
REQ-029 Reset held 3 cycles, released -> one cycle later frame_start = 1, pixel_x_pos = 0, pixel_y_pos = 0, video_active = 1; then frame_start = 0 for 419999 cycles.
REQ-030 Free run one line -> vga_hsync = 0 exactly while pixel_x_pos in 656..751 (96 cycles); video_active = 0 for pixel_x_pos 640..799.
REQ-031 Free run one frame -> vga_vsync = 0 exactly while pixel_y_pos in 490..491 (1600 cycles); video_active = 0 for all of lines 480..524.
REQ-032 Counters at (x=3, y=5) -> framebuffer_address = 641; at (639, 479) -> 76799; at (640, 0) -> 0; RAM-model data appears with pixel_x_pos = 3, pixel_y_pos = 5 next cycle.
REQ-033 frame_select_memory toggled 0->1 at line 100 -> frame_select_latched stays 0 until counters reach (0, 480), then 1; toggle at line 481 not seen until the next frame's line 480.
REQ-034 Reset asserted at (x=400, y=300) for 1 cycle -> outputs at reset values next cycle; frame_start pulse 1 cycle after deassertion; frame_select_latched = 0.

Source files
------------

// File: rtl/video_timing_generator.sv
// video_timing_generator: VGA line/frame counters, framebuffer read address and
// outputs delayed one clock so they line up with synchronous RAM read data.
module video_timing_generator #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int FB_WIDTH  = 320
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_select_memory,
   output logic [16:0] framebuffer_address,
   output logic [9:0]  pixel_x_pos,
   output logic [9:0]  pixel_y_pos,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        video_active,
   output logic        frame_start,
   output logic        frame_select_latched
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   logic [9:0] h_count, v_count;
   logic       h_wrap, v_wrap, in_visible, hsync, vsync;
   always_comb begin
      h_wrap = h_count == 10'(H_TOTAL - 1);
      v_wrap = v_count == 10'(V_TOTAL - 1);
      in_visible = h_count < 10'(H_VISIBLE) && v_count < 10'(V_VISIBLE);
      hsync = !(h_count >= 10'(H_VISIBLE + H_FRONT) && h_count < 10'(H_VISIBLE + H_FRONT + H_SYNC));
      vsync = !(v_count >= 10'(V_VISIBLE + V_FRONT) && v_count < 10'(V_VISIBLE + V_FRONT + V_SYNC));
      // each framebuffer pixel covers a 2x2 block of screen pixels
      framebuffer_address = in_visible ? 17'(v_count[9:1]) * 17'(FB_WIDTH) + 17'(h_count[9:1]) : '0;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         h_count              <= '0;
         v_count              <= '0;
         pixel_x_pos          <= '0;
         pixel_y_pos          <= '0;
         vga_hsync            <= 1'b1;
         vga_vsync            <= 1'b1;
         video_active         <= 1'b0;
         frame_start          <= 1'b0;
         frame_select_latched <= 1'b0;
      end else begin
         h_count      <= h_wrap ? '0 : h_count + 10'd1;
         if (h_wrap) v_count <= v_wrap ? '0 : v_count + 10'd1;
         pixel_x_pos  <= h_count;
         pixel_y_pos  <= v_count;
         vga_hsync    <= hsync;
         vga_vsync    <= vsync;
         video_active <= in_visible;
         frame_start  <= h_count == '0 && v_count == '0;
         // swap only at the start of vertical blanking so a frame is never torn
         if (h_count == '0 && v_count == 10'(V_VISIBLE)) frame_select_latched <= frame_select_memory;
      end
   end
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: two instances (default VGA timing and a tiny timing)
// checked every cycle against a model that derives positions from elapsed cycles.
module tb_video_timing_generator;
   localparam int HV [2] = '{640, 16};
   localparam int HF [2] = '{16, 2};
   localparam int HS [2] = '{96, 4};
   localparam int HT [2] = '{800, 25};
   localparam int VV [2] = '{480, 12};
   localparam int VF [2] = '{10, 2};
   localparam int VS [2] = '{2, 2};
   localparam int VT [2] = '{525, 19};
   localparam int FB [2] = '{320, 8};
   logic clk = 0;
   always #5 clk = ~clk;
   logic        rst [2];
   logic        fsm [2];
   logic [16:0] fa [2];
   logic [9:0]  px [2];
   logic [9:0]  py [2];
   logic        hs [2];
   logic        vs [2];
   logic        act [2];
   logic        fs [2];
   logic        fl [2];
   logic [16:0] ram_q;
   int          km [2];
   logic        lat [2];
   bit          live [2];
   int          checks = 0;
   int          fails = 0;
   int          hlow0 = 0;
   int          vlow1 = 0;

   video_timing_generator u0 (
      .clock(clk), .reset(rst[0]), .frame_select_memory(fsm[0]),
      .framebuffer_address(fa[0]), .pixel_x_pos(px[0]), .pixel_y_pos(py[0]),
      .vga_hsync(hs[0]), .vga_vsync(vs[0]), .video_active(act[0]),
      .frame_start(fs[0]), .frame_select_latched(fl[0]));

   video_timing_generator #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
      .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .FB_WIDTH(8)
   ) u1 (
      .clock(clk), .reset(rst[1]), .frame_select_memory(fsm[1]),
      .framebuffer_address(fa[1]), .pixel_x_pos(px[1]), .pixel_y_pos(py[1]),
      .vga_hsync(hs[1]), .vga_vsync(vs[1]), .video_active(act[1]),
      .frame_start(fs[1]), .frame_select_latched(fl[1]));

   // synchronous RAM whose word at address a holds a
   always @(posedge clk) ram_q <= fa[0];

   function automatic int hp(int i, int k);
      return k % HT[i];
   endfunction
   function automatic int vp(int i, int k);
      return (k / HT[i]) % VT[i];
   endfunction
   function automatic bit vis(int i, int h, int v);
      return h < HV[i] && v < VV[i];
   endfunction
   function automatic int ea(int i, int h, int v);
      return vis(i, h, v) ? (v / 2) * FB[i] + h / 2 : 0;
   endfunction

   task automatic chk(string name, int i, longint got, longint exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s dut%0d k=%0d: got %0d expected %0d", name, i, km[i], got, exp);
      end
   endtask

   // model: km = clock edges since reset released
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            km[i] = 0;
            lat[i] = 0;
            live[i] = 1;
         end else if (live[i]) begin
            if (hp(i, km[i]) == 0 && vp(i, km[i]) == VV[i]) lat[i] = fsm[i];
            km[i]++;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int k, h, v, ph, pv;
         if (live[i]) begin
            k = km[i];
            h = hp(i, k);
            v = vp(i, k);
            chk("address", i, fa[i], ea(i, h, v));
            chk("latched", i, fl[i], lat[i]);
            if (k == 0) begin
               chk("px_reset", i, px[i], 0);
               chk("py_reset", i, py[i], 0);
               chk("hsync_reset", i, hs[i], 1);
               chk("vsync_reset", i, vs[i], 1);
               chk("active_reset", i, act[i], 0);
               chk("frame_start_reset", i, fs[i], 0);
            end else begin
               ph = hp(i, k - 1);
               pv = vp(i, k - 1);
               chk("px", i, px[i], ph);
               chk("py", i, py[i], pv);
               chk("hsync", i, hs[i], !(ph >= HV[i] + HF[i] && ph < HV[i] + HF[i] + HS[i]));
               chk("vsync", i, vs[i], !(pv >= VV[i] + VF[i] && pv < VV[i] + VF[i] + VS[i]));
               chk("active", i, act[i], vis(i, ph, pv));
               chk("frame_start", i, fs[i], ph == 0 && pv == 0);
               if (i == 0 && vis(i, ph, pv)) chk("ram_data", i, ram_q, (pv / 2) * FB[i] + ph / 2);
            end
            if (k == 1) begin
               chk("first_frame_start", i, fs[i], 1);
               chk("first_active", i, act[i], 1);
            end
            if (i == 0) begin
               if (k == 0) hlow0 = 0;
               if (k >= 1 && k <= 800 && !hs[0]) hlow0++;
               if (k == 801) chk("hsync_low_per_line", 0, hlow0, 96);
               if (k == 640) chk("addr_hblank", 0, fa[0], 0);
               if (k == 4003) chk("addr_3_5", 0, fa[0], 641);
               if (k == 4004) begin
                  chk("ram_3_5", 0, ram_q, 641);
                  chk("ram_px", 0, px[0], 3);
                  chk("ram_py", 0, py[0], 5);
               end
            end else begin
               if (k == 0) vlow1 = 0;
               if (k >= 1 && k <= 475 && !vs[1]) vlow1++;
               if (k == 476) chk("vsync_low_per_frame", 1, vlow1, 50);
               if (h == 15 && v == 11) chk("addr_max", 1, fa[1], 47);
            end
         end
      end
   end

   task automatic wait_k(int i, int t);
      int n = 0;
      while (km[i] != t && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("wait_k", i, km[i], t);
   endtask

   initial begin
      int t;
      rst[0] = 1;
      rst[1] = 1;
      fsm[0] = 0;
      fsm[1] = 0;
      repeat (3) @(negedge clk);
      rst[0] = 0;
      rst[1] = 0;
      for (int n = 0; n < 4810; n++) begin
         @(negedge clk);
         fsm[0] = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 40) == 0) fsm[1] = ~fsm[1];
         rst[1] = n > 1000 && $urandom_range(0, 299) == 0;
      end
      rst[1] = 0;
      fsm[1] = 0;
      @(negedge clk);
      t = km[1] - km[1] % 475 + 7 * 25 + 10;
      if (t <= km[1]) t += 475;
      wait_k(1, t);
      rst[1] = 1;
      @(negedge clk);
      rst[1] = 0;
      chk("abort_latched", 1, fl[1], 0);
      chk("abort_px", 1, px[1], 0);
      chk("abort_active", 1, act[1], 0);
      wait_k(1, 100);
      fsm[1] = 1;
      wait_k(1, 300);
      chk("latch_hold_before", 1, fl[1], 0);
      wait_k(1, 301);
      chk("latch_load", 1, fl[1], 1);
      wait_k(1, 325);
      fsm[1] = 0;
      wait_k(1, 775);
      chk("latch_hold_next", 1, fl[1], 1);
      wait_k(1, 776);
      chk("latch_reload", 1, fl[1], 0);
      repeat (20) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
